eth_recv: RTL and testbench

Receive-side counterpart of the DNS-response frame generator on the VC709 10G path. It sits on the MAC RX AXI4-Stream, captures the first 48 bytes of every frame, and classifies each frame as Ethernet/IPv4/UDP/DNS-response addressed to this node. It validates the IPv4 header checksum and emits per-frame header fields plus running statistics counters for the DDoS emulator measurement logic.

---
 rtl/dns_pkg.sv | 24 ++
 rtl/endian_pkg.sv | 14 +
 rtl/eth_recv_pkg.sv | 23 ++
 rtl/ethernet_pkg.sv | 13 +
 rtl/ip_pkg.sv | 20 ++
 rtl/udp_pkg.sv | 11 +
 rtl/ip_csum_verify.sv | 33 +++
 rtl/eth_recv.sv | 158 +++++++++++++++
 tb/tb_eth_recv.sv | 319 +++++++++++++++++++++++++++++++
 9 files changed

// File: rtl/dns_pkg.sv
// 48-byte ETH/IP/UDP/DNS header union shared by the DNS transmitter and receiver.
package dns_pkg;

  typedef struct packed {
    logic [15:0] id;
    logic        qr;
    logic [3:0]  opcode;
    logic        aa;
    logic        tc;
    logic        rd;
    logic        ra;
    logic [2:0]  z;
    logic [3:0]  rcode;
  } dnshdr_t;

  typedef struct packed {
    ethernet_pkg::ethhdr_t eth;
    ip_pkg::iphdr_t        ip;
    udp_pkg::udphdr_t      udp;
    dnshdr_t               dns;
    logic [15:0]           pad;
  } dnspkt_t;

endpackage

// File: rtl/endian_pkg.sv
// Byte-order helpers shared by the 10G datapath blocks.
package endian_pkg;

  // Reverse the byte order of a 64-bit AXI beat so the earliest wire byte lands in the MSB.
  function automatic logic [63:0] endian_conv64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_recv_pkg.sv
// Receiver-local FSM states, header geometry and helpers for eth_recv.
package eth_recv_pkg;

  typedef enum logic [1:0] {
    RX_SYNC,
    RX_IDLE,
    RX_HDR,
    RX_BODY
  } rx_state_t;

  localparam int          HDR_BEATS     = 6;
  localparam logic [15:0] LAST_HDR_BEAT = 16'd5;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ethernet_pkg.sv
// Ethernet II header layout and ethertype constants.
package ethernet_pkg;

  localparam logic [15:0] ETH_P_IP  = 16'h0800;
  localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [47:0] h_dest;
    logic [47:0] h_source;
    logic [15:0] h_proto;
  } ethhdr_t;

endpackage

// File: rtl/ip_pkg.sv
// IPv4 header layout (no options) and protocol numbers.
package ip_pkg;

  localparam logic [7:0] IP4_PROTO_UDP = 8'd17;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] check;
    logic [31:0] saddr;
    logic [31:0] daddr;
  } iphdr_t;

endpackage

// File: rtl/udp_pkg.sv
// UDP header layout.
package udp_pkg;

  typedef struct packed {
    logic [15:0] source;
    logic [15:0] dest;
    logic [15:0] len;
    logic [15:0] check;
  } udphdr_t;

endpackage

// File: rtl/ip_csum_verify.sv
// Combinational IPv4 header checksum check: pass=1 when the one's-complement sum is 16'hFFFF.
module ip_csum_verify #(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic [159:0] ip_hdr,
  output logic         pass
);

  generate
    if (CSUM_EN) begin : g_sum
      logic [19:0] acc;
      logic [16:0] fold1;
      logic [15:0] fold2;

      // Ten 16-bit words fit in 20 bits; two folds always bring the carry back in.
      always_comb begin
        acc = '0;
        for (int i = 0; i < 10; i++) begin
          acc = acc + {4'h0, ip_hdr[16*i +: 16]};
        end
      end

      assign fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
      assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
      assign pass  = (fold2 == 16'hFFFF);
    end else begin : g_bypass
      logic unused_hdr;
      assign unused_hdr = ^ip_hdr;
      assign pass       = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/eth_recv.sv
// MAC RX frame classifier: captures 48 header bytes, matches DNS responses to this node, keeps stats.
// Define ETH_RECV_CSUM_EN to verify the IPv4 header checksum; otherwise every header passes.
module eth_recv #(
  parameter logic [47:0] MY_MAC    = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [31:0] MY_IP     = {8'd10, 8'd0, 8'd0, 8'd1},
  parameter logic [15:0] DNS_SPORT = 16'd53,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  input  logic                 m_axis_rx_tvalid,
  input  logic [63:0]          m_axis_rx_tdata,
  input  logic [7:0]           m_axis_rx_tkeep,
  input  logic                 m_axis_rx_tlast,
  input  logic                 m_axis_rx_tuser,
  output logic                 hdr_valid,
  output logic [31:0]          hdr_saddr,
  output logic [15:0]          hdr_dport,
  output logic [15:0]          hdr_len,
  output logic [CNT_WIDTH-1:0] cnt_rx_frames,
  output logic [CNT_WIDTH-1:0] cnt_rx_dns,
  output logic [CNT_WIDTH-1:0] cnt_rx_runt,
  output logic [CNT_WIDTH-1:0] cnt_rx_err,
  output logic [CNT_WIDTH-1:0] cnt_rx_bad_csum,
  output logic [CNT_WIDTH-1:0] cnt_rx_bytes
);
  import eth_recv_pkg::*;
  import endian_pkg::*;
  import ethernet_pkg::*;
  import ip_pkg::*;
  import dns_pkg::*;

`ifdef ETH_RECV_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  rx_state_t                      state_reg, state_next;
  logic [15:0]                    beat_cnt_reg, beat_cnt_next;
  logic [0:HDR_BEATS-1][63:0]     hdr_words_reg;
  dnspkt_t                        hdr;
  logic                           hdr_we, runt_end, frame_end;
  logic [19:0]                    len_full;
  logic [15:0]                    frame_len;
  logic                           dest_ok, dns_match, csum_ok;
  logic                           unused_hdr;

  // Word 0 is the earliest beat, so the packed overlay reads fields in wire order.
  assign hdr        = dnspkt_t'(hdr_words_reg);
  assign unused_hdr = ^hdr;

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    hdr_we        = 1'b0;
    runt_end      = 1'b0;
    frame_end     = 1'b0;
    if (m_axis_rx_tvalid) begin
      case (state_reg)
        RX_SYNC: begin
          if (m_axis_rx_tlast) state_next = RX_IDLE;
        end
        RX_IDLE, RX_HDR: begin
          hdr_we = 1'b1;
          if (m_axis_rx_tlast) begin
            runt_end      = 1'b1;
            beat_cnt_next = '0;
            state_next    = RX_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 16'd1;
            state_next    = (beat_cnt_reg == LAST_HDR_BEAT) ? RX_BODY : RX_HDR;
          end
        end
        RX_BODY: begin
          if (m_axis_rx_tlast) begin
            frame_end     = 1'b1;
            beat_cnt_next = '0;
            state_next    = RX_IDLE;
          end else if (beat_cnt_reg != 16'hFFFF) begin
            beat_cnt_next = beat_cnt_reg + 16'd1;
          end
        end
        default: state_next = RX_SYNC;
      endcase
    end
  end

  // beat_cnt_reg holds beats-1 on the tlast beat, so this is 8*(beats-1)+popcount.
  assign len_full  = {1'b0, beat_cnt_reg, 3'b000} + {16'h0000, popcount8(m_axis_rx_tkeep)};
  assign frame_len = (len_full[19:16] != 4'h0) ? 16'hFFFF : len_full[15:0];

  assign dest_ok   = (hdr.eth.h_dest == MY_MAC) || (hdr.eth.h_dest == ETH_BCAST);
  assign dns_match = dest_ok && (hdr.eth.h_proto == ETH_P_IP) &&
                     (hdr.ip.version == 4'd4) && (hdr.ip.ihl == 4'd5) &&
                     (hdr.ip.protocol == IP4_PROTO_UDP) && (hdr.ip.daddr == MY_IP) &&
                     (hdr.udp.source == DNS_SPORT) && hdr.dns.qr;

  ip_csum_verify #(.CSUM_EN(CSUM_EN)) u_csum (
    .ip_hdr (hdr.ip),
    .pass   (csum_ok)
  );

  always_ff @(posedge clk156) begin
    if (hdr_we) hdr_words_reg[beat_cnt_reg[2:0]] <= endian_conv64(m_axis_rx_tdata);
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_reg       <= RX_SYNC;
      beat_cnt_reg    <= '0;
      hdr_valid       <= 1'b0;
      hdr_saddr       <= '0;
      hdr_dport       <= '0;
      hdr_len         <= '0;
      cnt_rx_frames   <= '0;
      cnt_rx_dns      <= '0;
      cnt_rx_runt     <= '0;
      cnt_rx_err      <= '0;
      cnt_rx_bytes    <= '0;
`ifdef ETH_RECV_CSUM_EN
      cnt_rx_bad_csum <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      hdr_valid    <= 1'b0;
      if (runt_end) begin
        cnt_rx_frames <= cnt_rx_frames + CNT_WIDTH'(1);
        cnt_rx_runt   <= cnt_rx_runt + CNT_WIDTH'(1);
      end
      if (frame_end) begin
        cnt_rx_frames <= cnt_rx_frames + CNT_WIDTH'(1);
        cnt_rx_bytes  <= cnt_rx_bytes + CNT_WIDTH'(frame_len);
        if (m_axis_rx_tuser) begin
          cnt_rx_err <= cnt_rx_err + CNT_WIDTH'(1);
        end
`ifdef ETH_RECV_CSUM_EN
        else if (!csum_ok) begin
          cnt_rx_bad_csum <= cnt_rx_bad_csum + CNT_WIDTH'(1);
        end
`endif
        else if (csum_ok && dns_match) begin
          cnt_rx_dns <= cnt_rx_dns + CNT_WIDTH'(1);
          hdr_valid  <= 1'b1;
          hdr_saddr  <= hdr.ip.saddr;
          hdr_dport  <= hdr.udp.dest;
          hdr_len    <= frame_len;
        end
      end
    end
  end

`ifndef ETH_RECV_CSUM_EN
  assign cnt_rx_bad_csum = '0;
`endif

endmodule

// File: tb/tb_eth_recv.sv
// Directed bench for eth_recv: frame-level reference model plus per-cycle output comparison.
module tb_eth_recv;
  localparam int          CW     = 32;
  localparam logic [47:0] MY_MAC = 48'h90E2BA5D8DC8;
  localparam logic [31:0] MY_IP  = 32'h0A000001;
`ifdef ETH_RECV_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int D = CSUM_EN ? 1 : 0;

  logic          clk156 = 1'b0;
  logic          sys_rst;
  logic          tvalid, tlast, tuser;
  logic [63:0]   tdata;
  logic [7:0]    tkeep;
  logic          hdr_valid;
  logic [31:0]   hdr_saddr;
  logic [15:0]   hdr_dport, hdr_len;
  logic [CW-1:0] cnt_rx_frames, cnt_rx_dns, cnt_rx_runt, cnt_rx_err, cnt_rx_bad_csum, cnt_rx_bytes;

  eth_recv #(.MY_MAC(MY_MAC), .MY_IP(MY_IP), .DNS_SPORT(16'd53), .CNT_WIDTH(CW)) dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .m_axis_rx_tvalid(tvalid), .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep),
    .m_axis_rx_tlast(tlast), .m_axis_rx_tuser(tuser),
    .hdr_valid(hdr_valid), .hdr_saddr(hdr_saddr), .hdr_dport(hdr_dport), .hdr_len(hdr_len),
    .cnt_rx_frames(cnt_rx_frames), .cnt_rx_dns(cnt_rx_dns), .cnt_rx_runt(cnt_rx_runt),
    .cnt_rx_err(cnt_rx_err), .cnt_rx_bad_csum(cnt_rx_bad_csum), .cnt_rx_bytes(cnt_rx_bytes)
  );

  always #5 clk156 = ~clk156;

  longint cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int frame_no = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]    frm [0:2047];
  int            frm_len;
  bit            synced;
  longint        valid_cyc;
  logic [CW-1:0] e_frames, e_dns, e_runt, e_err, e_bad, e_bytes;
  logic [31:0]   e_saddr;
  logic [15:0]   e_dport, e_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] fold_sum(input logic [159:0] h);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 10; i++) s += 32'(h[16*i +: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [159:0] get_iphdr();
    logic [159:0] h;
    h = '0;
    for (int i = 0; i < 20; i++) h = {h[151:0], frm[14+i]};
    return h;
  endfunction

  function automatic bit model_match();
    logic [47:0] d;
    logic [31:0] da;
    d = '0;
    da = '0;
    for (int k = 0; k < 6; k++) d = {d[39:0], frm[k]};
    for (int k = 0; k < 4; k++) da = {da[23:0], frm[30+k]};
    return ((d == MY_MAC) || (d == 48'hFFFF_FFFF_FFFF)) && frm[12] == 8'h08 && frm[13] == 8'h00 &&
           frm[14] == 8'h45 && frm[23] == 8'd17 && da == MY_IP &&
           {frm[34], frm[35]} == 16'd53 && frm[44][7];
  endfunction

  task automatic put16(input int off, input logic [15:0] v);
    frm[off]   = v[15:8];
    frm[off+1] = v[7:0];
  endtask

  task automatic build_dns(input logic [31:0] saddr, input logic [15:0] dport, input int len,
                           input logic [47:0] dmac, input logic [15:0] sport);
    logic [15:0] c;
    frm_len = len;
    for (int i = 0; i < 2048; i++) frm[i] = 8'(i * 7 + 3);
    for (int k = 0; k < 6; k++) frm[k] = dmac[47-8*k -: 8];
    for (int k = 6; k < 12; k++) frm[k] = 8'h02;
    put16(12, 16'h0800);
    frm[14] = 8'h45; frm[15] = 8'h00;
    put16(16, 16'(len - 14)); put16(18, 16'h1234); put16(20, 16'h4000);
    frm[22] = 8'h40; frm[23] = 8'd17; put16(24, 16'h0000);
    put16(26, saddr[31:16]); put16(28, saddr[15:0]);
    put16(30, MY_IP[31:16]); put16(32, MY_IP[15:0]);
    put16(34, sport); put16(36, dport); put16(38, 16'(len - 34)); put16(40, 16'h0000);
    put16(42, 16'hBEEF); frm[44] = 8'h81; frm[45] = 8'h80; put16(46, 16'h0000);
    c = ~fold_sum(get_iphdr());
    put16(24, c);
  endtask

  task automatic model_reset();
    synced = 1'b0; valid_cyc = -1;
    e_frames = '0; e_dns = '0; e_runt = '0; e_err = '0; e_bad = '0; e_bytes = '0;
    e_saddr = '0; e_dport = '0; e_len = '0;
  endtask

  task automatic model_frame(input bit tu);
    int nb;
    logic [15:0] len;
    if (!synced) begin
      synced = 1'b1;
      return;
    end
    nb = (frm_len + 7) / 8;
    e_frames = e_frames + 1;
    if (nb <= 6) begin
      e_runt = e_runt + 1;
      return;
    end
    len = (frm_len > 65535) ? 16'hFFFF : 16'(frm_len);
    e_bytes = e_bytes + CW'(len);
    if (tu) e_err = e_err + 1;
    else if (CSUM_EN && fold_sum(get_iphdr()) != 16'hFFFF) e_bad = e_bad + 1;
    else if (model_match()) begin
      e_dns = e_dns + 1;
      valid_cyc = cyc;
      e_saddr = {frm[26], frm[27], frm[28], frm[29]};
      e_dport = {frm[36], frm[37]};
      e_len = len;
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (n) begin @(posedge clk156); #1; end
  endtask

  task automatic send_frame(input bit tu_last, input int gap_pct, input int rst_beat);
    int nb, idx;
    nb = (frm_len + 7) / 8;
    frame_no++;
    $display("tx frame %0d: len=%0d beats=%0d tuser=%0b gap_pct=%0d rst_beat=%0d",
             frame_no, frm_len, nb, tu_last, gap_pct, rst_beat);
    for (int b = 0; b < nb; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        tvalid = 1'b0; tdata = {$urandom, $urandom}; tkeep = 8'($urandom);
        tlast = 1'($urandom); tuser = 1'($urandom);
        @(posedge clk156); #1;
      end
      tvalid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        idx = 8 * b + k;
        tdata[8*k +: 8] = (idx < frm_len) ? frm[idx] : 8'h00;
        tkeep[k] = (idx < frm_len);
      end
      tlast = (b == nb - 1);
      tuser = tlast ? tu_last : 1'($urandom);
      sys_rst = (b == rst_beat);
      @(posedge clk156); #1;
      if (b == rst_beat) model_reset();
      else if (tlast) model_frame(tu_last);
      sys_rst = 1'b0;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk156);
      if (chk_en) begin
        chk("hdr_valid", hdr_valid, (cyc == valid_cyc));
        chk("hdr_saddr", hdr_saddr, e_saddr);
        chk("hdr_dport", hdr_dport, e_dport);
        chk("hdr_len", hdr_len, e_len);
        chk("cnt_rx_frames", cnt_rx_frames, e_frames);
        chk("cnt_rx_dns", cnt_rx_dns, e_dns);
        chk("cnt_rx_runt", cnt_rx_runt, e_runt);
        chk("cnt_rx_err", cnt_rx_err, e_err);
        chk("cnt_rx_bad_csum", cnt_rx_bad_csum, e_bad);
        chk("cnt_rx_bytes", cnt_rx_bytes, e_bytes);
        if (hdr_valid === 1'b1) pulses++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [159:0] h;
    int p0;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
    sys_rst = 1'b1;
    model_reset();

    // Pin the model's checksum arithmetic against a textbook header
    h = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
    chk("model_csum_sum", fold_sum(h), 16'h479E);
    h[79:64] = 16'hB861;
    chk("model_csum_ok", fold_sum(h), 16'hFFFF);

    @(posedge clk156); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk156); #1; end
    sys_rst = 1'b0;
    chk("rst_frames", cnt_rx_frames, 0);
    chk("rst_valid", hdr_valid, 0);
    chk("rst_len", hdr_len, 0);
    idle(3);

    // First frame after reset is consumed by resynchronisation
    build_dns(32'h0A010201, 16'd50001, 1020, MY_MAC, 16'd53);
    send_frame(1'b0, 0, -1);
    idle(2);
    chk("sync_drop_frames", cnt_rx_frames, 0);
    chk("sync_drop_dns", cnt_rx_dns, 0);

    send_frame(1'b0, 0, -1);
    chk("t1_valid_pulse", hdr_valid, 1);
    idle(2);
    chk("t1_len", hdr_len, 1020);
    chk("t1_dport", hdr_dport, 50001);
    chk("t1_saddr", hdr_saddr, 32'h0A010201);
    chk("t1_dns", cnt_rx_dns, 1);
    chk("t1_bytes", cnt_rx_bytes, 1020);

    // Corrupted IP checksum
    frm[25] = frm[25] ^ 8'h01;
    send_frame(1'b0, 0, -1);
    idle(2);
    chk("t2_bad_csum", cnt_rx_bad_csum, D);
    chk("t2_dns", cnt_rx_dns, 2 - D);
    chk("t2_frames", cnt_rx_frames, 2);

    // Wrong destination MAC, wrong source port, MAC error
    p0 = pulses;
    build_dns(32'h0A010203, 16'd50002, 1020, 48'h001122334455, 16'd53);
    send_frame(1'b0, 0, -1);
    build_dns(32'h0A010203, 16'd50002, 1020, MY_MAC, 16'd54);
    send_frame(1'b0, 0, -1);
    build_dns(32'h0A010203, 16'd50002, 1020, MY_MAC, 16'd53);
    send_frame(1'b1, 0, -1);
    idle(2);
    chk("t3_frames", cnt_rx_frames, 5);
    chk("t3_err", cnt_rx_err, 1);
    chk("t3_no_pulse", pulses - p0, 0);
    chk("t3_bytes", cnt_rx_bytes, 5100);

    // Broadcast destination is accepted
    build_dns(32'h0A090909, 16'd1234, 1020, 48'hFFFF_FFFF_FFFF, 16'd53);
    send_frame(1'b0, 0, -1);
    idle(2);
    chk("bcast_dns", cnt_rx_dns, 3 - D);
    chk("bcast_saddr", hdr_saddr, 32'h0A090909);

    // Runt boundary: 40 and 48 bytes are runts, 49 bytes is a full frame
    build_dns(32'h0A010204, 16'd50003, 40, MY_MAC, 16'd53);
    send_frame(1'b0, 0, -1);
    idle(2);
    chk("t4_runt", cnt_rx_runt, 1);
    chk("t4_bytes", cnt_rx_bytes, 6120);
    build_dns(32'h0A010204, 16'd50003, 48, MY_MAC, 16'd53);
    send_frame(1'b0, 0, -1);
    build_dns(32'h0A010205, 16'd50004, 49, MY_MAC, 16'd53);
    send_frame(1'b0, 0, -1);
    idle(2);
    chk("t4_runt48", cnt_rx_runt, 2);
    chk("t4_len49", hdr_len, 49);
    chk("t4_bytes49", cnt_rx_bytes, 6169);
    chk("t4_frames", cnt_rx_frames, 9);

    // 100 back-to-back frames with random single-cycle gaps
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      build_dns({8'd10, 8'd1, 8'd2, 8'(i)}, 16'(50001 + i), 1020, MY_MAC, 16'd53);
      send_frame(1'b0, 25, -1);
    end
    idle(3);
    chk("t5_pulses", pulses - p0, 100);
    chk("t5_bytes", cnt_rx_bytes, 6169 + 102000);
    chk("t5_dns", cnt_rx_dns, 104 - D);

    // Reset in the middle of a frame
    build_dns(32'h0A010206, 16'd50100, 1020, MY_MAC, 16'd53);
    send_frame(1'b0, 0, 30);
    chk("t6_frames", cnt_rx_frames, 0);
    chk("t6_bytes", cnt_rx_bytes, 0);
    chk("t6_err", cnt_rx_err, 0);
    chk("t6_saddr", hdr_saddr, 0);
    idle(2);
    build_dns(32'h0A010207, 16'd50200, 1020, MY_MAC, 16'd53);
    send_frame(1'b0, 0, -1);
    chk("t6_valid", hdr_valid, 1);
    idle(2);
    chk("t6_dns", cnt_rx_dns, 1);
    chk("t6_dport", hdr_dport, 50200);
    chk("t6_bytes_after", cnt_rx_bytes, 1020);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
